// File: rtl/rf_wport_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NREQ writeback sources, plus a RAW scoreboard.
// One accepted write per cycle, presented on registered We/Wr/D one cycle later; losers see req_ready=0 and hold.
module rf_wport_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic                 Clk,
   input  logic                 Clrn,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*AW-1:0]   req_wr,
   input  logic [NREQ*DW-1:0]   req_d,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 resv_valid,
   input  logic [AW-1:0]        resv_wr,
   output logic                 We,
   output logic [AW-1:0]        Wr,
   output logic [DW-1:0]        D,
   output logic [2:0]           grant_id,
   output logic [2**AW-1:0]     busy
);

   logic [2:0]       last_q, last_d;
   logic             we_q, we_d;
   logic [AW-1:0]    wr_q, wr_d;
   logic [DW-1:0]    data_q, data_d;
   logic [2:0]       gid_q, gid_d;
   logic [2**AW-1:0] busy_q, busy_d;

   logic [2:0]       win;
   logic             xfer;
   logic [AW-1:0]    win_wr;
   logic [DW-1:0]    win_d;

   // Walk from the lowest priority slot up so the closest requester after last wins.
   always_comb begin
      win  = '0;
      xfer = 1'b0;
      for (int k = NREQ; k >= 1; k--) begin
         if (req_valid[(int'(last_q) + k) % NREQ]) begin
            win  = 3'((int'(last_q) + k) % NREQ);
            xfer = 1'b1;
         end
      end
      req_ready = NREQ'(xfer) << win;
      win_wr    = req_wr[int'(win)*AW +: AW];
      win_d     = req_d[int'(win)*DW +: DW];
   end

   always_comb begin
      last_d = last_q;
      we_d   = 1'b0;
      wr_d   = wr_q;
      data_d = data_q;
      gid_d  = gid_q;
      busy_d = busy_q;
      if (xfer) begin
         we_d   = (win_wr != '0);
         wr_d   = win_wr;
         data_d = win_d;
         gid_d  = win;
         last_d = win;
         if (win_wr != '0) busy_d[win_wr] = 1'b0;
      end
      // Applied after the clear so a same-cycle reservation of the same register wins.
      if (resv_valid && (resv_wr != '0)) busy_d[resv_wr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         last_q <= 3'(NREQ - 1);
         we_q   <= 1'b0;
         wr_q   <= '0;
         data_q <= '0;
         gid_q  <= '0;
         busy_q <= '0;
      end else begin
         last_q <= last_d;
         we_q   <= we_d;
         wr_q   <= wr_d;
         data_q <= data_d;
         gid_q  <= gid_d;
         busy_q <= busy_d;
      end
   end

   assign We       = we_q;
   assign Wr       = wr_q;
   assign D        = data_q;
   assign grant_id = gid_q;
   assign busy     = busy_q;

endmodule
